// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew data-hazard stall unit for a 5-stage MIPS pipeline, with an MDU
// busy tracker for HI/LO instructions and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int REG_W       = 5,
  parameter int T_W         = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [REG_W-1:0]           rs_d,
  input  logic [REG_W-1:0]           rt_d,
  input  logic [T_W-1:0]             tuse_rs_d,
  input  logic [T_W-1:0]             tuse_rt_d,
  input  logic [REG_W-1:0]           a3_d,
  input  logic [T_W-1:0]             tnew_d,
  input  logic                       md_d,
  input  logic                       start_e,
  input  logic                       div_e,
  output logic                       stall,
  output logic                       bubble_e,
  output logic                       md_busy,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [3*(REG_W+T_W)-1:0]   dbg_pipe
);

  localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int MD_W   = $clog2(MD_MAX + 1);
  localparam logic [T_W-1:0] TUSE_NONE = '1;

  logic [REG_W-1:0] a3_e, a3_m, a3_w;
  logic [T_W-1:0]   tnew_e, tnew_m, tnew_w;
  logic [MD_W-1:0]  md_cnt;
  logic             rs_haz, rt_haz, md_haz;

  function automatic logic [T_W-1:0] dec_sat(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - T_W'(1);
  endfunction

  function automatic logic src_haz(input logic [REG_W-1:0] r,
                                   input logic [T_W-1:0]   tuse,
                                   input logic [REG_W-1:0] ae,
                                   input logic [T_W-1:0]   te,
                                   input logic [REG_W-1:0] am,
                                   input logic [T_W-1:0]   tm);
    logic h;
    h = 1'b0;
    if (r != '0 && tuse != TUSE_NONE) begin
      if (r == ae && te > tuse) h = 1'b1;
      if (r == am && tm > tuse) h = 1'b1;
    end
    return h;
  endfunction

  // W is deliberately excluded: with tnew <= 2 its remaining tnew is always 0.
  always_comb begin
    rs_haz   = src_haz(rs_d, tuse_rs_d, a3_e, tnew_e, a3_m, tnew_m);
    rt_haz   = src_haz(rt_d, tuse_rt_d, a3_e, tnew_e, a3_m, tnew_m);
    md_busy  = (md_cnt != '0);
    md_haz   = md_d && (md_busy || start_e);
    stall    = rs_haz || rt_haz || md_haz;
    bubble_e = stall;
    dbg_pipe = {a3_e, tnew_e, a3_m, tnew_m, a3_w, tnew_w};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a3_e   <= '0;
      tnew_e <= '0;
      a3_m   <= '0;
      tnew_m <= '0;
      a3_w   <= '0;
      tnew_w <= '0;
    end else begin
      if (stall) begin
        a3_e   <= '0;
        tnew_e <= '0;
      end else begin
        a3_e   <= a3_d;
        tnew_e <= tnew_d;
      end
      a3_m   <= a3_e;
      tnew_m <= dec_sat(tnew_e);
      a3_w   <= a3_m;
      tnew_w <= dec_sat(tnew_m);
    end
  end

  // A new start always reloads, even over a running operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (start_e) begin
      md_cnt <= div_e ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised Tuse/Tnew data-hazard stall unit for the 5-stage MIPS pipeline.
- Tracks the destination register and remaining Tnew of instructions in E/M/W internally; the D stage supplies only the decoded source and destination fields.
- Adds a multiply/divide busy tracker that stalls HI/LO instructions in D while the MDU is running.
- Adds a saturating stall-cycle performance counter.
- Sits beside the D stage; drives the PC/IF-ID freeze and the ID/EX bubble.

Parameters:
- REG_W, 5, register-address width; address 0 is never a hazard.
- T_W, 2, Tuse/Tnew field width.
- MULT_CYCLES, 5, MDU busy cycles after a mult/multu start.
- DIV_CYCLES, 10, MDU busy cycles after a div/divu start.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- rs_d  in  REG_W  rs field of the instruction in D.
- rt_d  in  REG_W  rt field of the instruction in D.
- tuse_rs_d  in  T_W  stage where rs is needed: 0=D (branch/jr), 1=E, 2=M, 3=unused.
- tuse_rt_d  in  T_W  same encoding for rt.
- a3_d  in  REG_W  destination register of the D instruction; 0 = no write.
- tnew_d  in  T_W  cycles after E entry until the result can be forwarded: ALU=1, load=2, jal/link=0.
- md_d  in  1  D instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo/mult/div).
- start_e  in  1  mult/div start pulse in E.
- div_e  in  1  with start_e: 1=div, 0=mult.
- stall  out  1  freeze PC and IF/ID.
- bubble_e  out  1  clear ID/EX next edge; equals stall.
- md_busy  out  1  MDU busy counter nonzero.
- stall_cnt  out  CNT_W  total stalled cycles.

Behaviour:
- Internal registers: a3_e/tnew_e, a3_m/tnew_m, a3_w/tnew_w.
- Reset (asynchronous) clears all a3/tnew registers, the MDU counter and stall_cnt to 0. Consequently stall=0, bubble_e=0, md_busy=0 while reset is asserted and afterwards.
- Each edge, E loading:
  - If stall=1, E loads a bubble: a3_e=0, tnew_e=0.
  - Otherwise E loads a3_d and tnew_d.
- Each edge, M and W loading:
  - M loads E, and W loads M.
  - tnew is decremented on each move, saturating at 0.
  - M and W are never frozen.
- rs hazard (combinational): rs_d!=0 and tuse_rs_d!=3 and either condition holds:
  - rs_d==a3_e and tnew_e>tuse_rs_d, or
  - rs_d==a3_m and tnew_m>tuse_rs_d.
- W never causes a stall: tnew_w is always 0 for legal tnew_d ≤ 2. The W register is kept for debug only.
- rt hazard: identical rule using rt_d and tuse_rt_d.
- MDU counter:
  - On start_e, load DIV_CYCLES if div_e, else MULT_CYCLES. Reload wins even if the counter is already nonzero.
  - Otherwise decrement when nonzero.
  - md_busy = (counter != 0).
- md hazard: md_d and (md_busy or start_e). The start cycle itself blocks D.
- stall = rs hazard | rt hazard | md hazard; bubble_e = stall. Zero latency from the D inputs.
- stall_cnt increments on each edge where stall=1 and saturates at all ones (no wrap).
- An edge case of a3_d==0 with tnew_d>0 is legal and never causes a stall.

Test Plan:
- Load-use: a3_d=8, tnew_d=2 (lw $8), then next cycle rs_d=8, tuse_rs_d=1 (addu) -> stall=1 for exactly 1 cycle, tnew_e=0 bubble inserted; the second cycle has stall=0; stall_cnt=1.
- Branch after ALU: addu $9 (tnew 1), then beq with rs_d=9, tuse_rs_d=0 -> stall 1 cycle. Same sequence with beq after lw -> stall 2 cycles; stall_cnt=2.
- Store data after load: lw $10, then sw with rt_d=10, tuse_rt_d=2 -> stall=0. Same sequence with rs_d=0, a3=0 -> stall=0.
- MDU: start_e=1, div_e=1 at cycle 0, mflo in D from cycle 0 -> stall=1 for cycles 0..10; md_busy high cycles 1..10; stall drops at cycle 11. Same with mult -> stall cycles 0..5.
- Reset mid-operation: assert reset during a div with busy count 6 and a pending load hazard -> md_busy=0 and stall=0 immediately (asynchronous); after release, mflo proceeds with no stall.
- Counter saturation with CNT_W=4: hold a hazard for 20 cycles -> stall_cnt reaches 15 and stays 15.
